// File: rtl/single_macc_decimator_pkg.sv
// rtl/single_macc_decimator_pkg.sv - shared widths, FSM states and round/saturate helper
// for the single-MAC FIR decimator.
package single_macc_decimator_pkg;

  localparam int DATA_W     = 18;
  localparam int PROD_W     = 36;
  localparam int ACC_W      = 48;
  localparam int FILTER_LEN = 16;
  localparam int BUF_DEPTH  = 32;
  localparam int COEF_AW    = 4;
  localparam int BUF_AW     = 5;
  localparam int OUT_LSB    = 17;
  localparam int OUT_MSB    = 34;
  localparam int RND_BIT    = 16;
  localparam int SHIFT_W    = ACC_W - OUT_LSB;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_DRAIN
  } state_t;

  // Half away from zero: negative values only round up past the exact half.
  function automatic logic [DATA_W-1:0] round_sat(input logic [ACC_W-1:0] acc);
    logic [SHIFT_W-1:0] t;
    logic               inc;
    inc = acc[RND_BIT] & (~acc[ACC_W-1] | (|acc[RND_BIT-1:0]));
    t   = acc[ACC_W-1:OUT_LSB] + {{(SHIFT_W-1){1'b0}}, inc};
    if (t[SHIFT_W-1:DATA_W-1] == {(SHIFT_W-DATA_W+1){t[DATA_W-1]}})
      return t[DATA_W-1:0];
    else if (t[SHIFT_W-1])
      return {1'b1, {(DATA_W-1){1'b0}}};
    else
      return {1'b0, {(DATA_W-1){1'b1}}};
  endfunction

endpackage

// File: rtl/decim_ctrl.sv
// rtl/decim_ctrl.sv - phase counter, buffer pointers, MAC sequencing FSM and overrun flag.
module decim_ctrl
  import single_macc_decimator_pkg::*;
#(
  parameter int DecimationK  = 2,
  parameter int FilterLength = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sample_nd,
  output logic [BUF_AW-1:0] wr_ptr,
  output logic [BUF_AW-1:0] rd_addr,
  output logic [COEF_AW-1:0] coef_addr,
  output logic              rd_en,
  output logic              first_tap,
  output logic              round_en,
  output logic              data_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [3:0]         LAST_PHASE = 4'(DecimationK - 1);
  localparam logic [COEF_AW-1:0] LAST_TAP   = COEF_AW'(FilterLength - 1);

  state_t             state;
  logic [3:0]         phase;
  logic [BUF_AW-1:0]  base;
  logic [COEF_AW-1:0] tap;
  logic [1:0]         drain_cnt;
  logic               trigger;

  assign trigger = sample_nd && (phase == LAST_PHASE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      phase      <= '0;
      wr_ptr     <= '0;
      base       <= '0;
      tap        <= '0;
      drain_cnt  <= '0;
      rd_addr    <= '0;
      coef_addr  <= '0;
      rd_en      <= 1'b0;
      first_tap  <= 1'b0;
      round_en   <= 1'b0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rd_en      <= 1'b0;
      first_tap  <= 1'b0;
      round_en   <= 1'b0;
      data_valid <= 1'b0;
      if (sample_nd) begin
        wr_ptr <= wr_ptr + 1'b1;
        phase  <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
      end
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (trigger) begin
            base  <= wr_ptr;
            tap   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          busy      <= 1'b1;
          rd_en     <= 1'b1;
          first_tap <= (tap == '0);
          rd_addr   <= base - {1'b0, tap};
          coef_addr <= tap;
          if (trigger) overrun <= 1'b1;
          if (tap == LAST_TAP) begin
            drain_cnt <= '0;
            state     <= ST_DRAIN;
          end else begin
            tap <= tap + 1'b1;
          end
        end
        ST_DRAIN: begin
          drain_cnt <= drain_cnt + 2'd1;
          if (drain_cnt == 2'd2) round_en <= 1'b1;
          // Last drain cycle: result is out, so a trigger here starts the next pass.
          if (drain_cnt == 2'd3) begin
            data_valid <= 1'b1;
            busy       <= 1'b0;
            if (trigger) begin
              base  <= wr_ptr;
              tap   <= '0;
              state <= ST_MAC;
            end else begin
              state <= ST_IDLE;
            end
          end else if (trigger) begin
            overrun <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/single_macc_decimator.sv
// rtl/single_macc_decimator.sv - 16-tap single-MAC FIR decimator: coefficient/data RAMs,
// MAC pipeline and round/saturate output stage.
module single_macc_decimator
  import single_macc_decimator_pkg::*;
#(
  parameter int DecimationK  = 2,
  parameter int FilterLength = 16,
  parameter int DataWidth    = 18
) (
  input  logic                 Clk_i,
  input  logic                 Rst_i,
  input  logic [3:0]           CoeffAddr_i,
  input  logic [DataWidth-1:0] CoeffData_i,
  input  logic                 CoeffWr_i,
  input  logic [DataWidth-1:0] Data_i,
  input  logic                 DataNd_i,
  output logic [DataWidth-1:0] Data_o,
  output logic                 DataValid_o,
  output logic                 Busy_o,
  output logic                 Overrun_o
);

  logic [DATA_W-1:0] coef_mem [0:FILTER_LEN-1];
  logic [DATA_W-1:0] data_mem [0:BUF_DEPTH-1];

  logic [BUF_AW-1:0]        wr_ptr;
  logic [BUF_AW-1:0]        rd_addr;
  logic [COEF_AW-1:0]       coef_addr;
  logic                     rd_en;
  logic                     first_tap;
  logic                     round_en;
  logic signed [DATA_W-1:0] data_q;
  logic signed [DATA_W-1:0] coef_q;
  logic signed [PROD_W-1:0] prod;
  logic        [ACC_W-1:0]  acc;
  logic        [ACC_W-1:0]  prod_ext;
  logic                     rd_vld;
  logic                     rd_first;
  logic                     prod_vld;
  logic                     prod_first;

  decim_ctrl #(
    .DecimationK (DecimationK),
    .FilterLength(FilterLength)
  ) u_ctrl (
    .clk       (Clk_i),
    .rst_n     (Rst_i),
    .sample_nd (DataNd_i),
    .wr_ptr    (wr_ptr),
    .rd_addr   (rd_addr),
    .coef_addr (coef_addr),
    .rd_en     (rd_en),
    .first_tap (first_tap),
    .round_en  (round_en),
    .data_valid(DataValid_o),
    .busy      (Busy_o),
    .overrun   (Overrun_o)
  );

  // Storage is deliberately not reset; the read pipeline only moves on rd_en.
  always_ff @(posedge Clk_i) begin
    if (CoeffWr_i) coef_mem[CoeffAddr_i] <= CoeffData_i;
    if (DataNd_i)  data_mem[wr_ptr]      <= Data_i;
    if (rd_en) begin
      data_q <= data_mem[rd_addr];
      coef_q <= coef_mem[coef_addr];
    end
  end

  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

  always_ff @(posedge Clk_i or negedge Rst_i) begin
    if (!Rst_i) begin
      rd_vld     <= 1'b0;
      rd_first   <= 1'b0;
      prod_vld   <= 1'b0;
      prod_first <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      Data_o     <= '0;
    end else begin
      rd_vld     <= rd_en;
      rd_first   <= first_tap;
      prod_vld   <= rd_vld;
      prod_first <= rd_first;
      if (rd_vld)   prod <= data_q * coef_q;
      if (prod_vld) acc  <= prod_first ? prod_ext : acc + prod_ext;
      if (round_en) Data_o <= round_sat(acc);
    end
  end

endmodule

// File: tb/tb_single_macc_decimator.sv
// tb/tb_single_macc_decimator.sv - directed self-checking bench for single_macc_decimator (K=2).
module tb_single_macc_decimator;

  localparam int GAP = 12;

  logic        Clk_i = 1'b0;
  logic        Rst_i = 1'b0;
  logic [3:0]  CoeffAddr_i = '0;
  logic [17:0] CoeffData_i = '0;
  logic        CoeffWr_i = 1'b0;
  logic [17:0] Data_i = '0;
  logic        DataNd_i = 1'b0;
  logic [17:0] Data_o;
  logic        DataValid_o;
  logic        Busy_o;
  logic        Overrun_o;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [17:0] vq[$];
  int          vc[$];

  single_macc_decimator #(
    .DecimationK (2),
    .FilterLength(16),
    .DataWidth   (18)
  ) dut (
    .Clk_i      (Clk_i),
    .Rst_i      (Rst_i),
    .CoeffAddr_i(CoeffAddr_i),
    .CoeffData_i(CoeffData_i),
    .CoeffWr_i  (CoeffWr_i),
    .Data_i     (Data_i),
    .DataNd_i   (DataNd_i),
    .Data_o     (Data_o),
    .DataValid_o(DataValid_o),
    .Busy_o     (Busy_o),
    .Overrun_o  (Overrun_o)
  );

  always #5 Clk_i = ~Clk_i;

  always @(posedge Clk_i) cyc <= cyc + 1;

  always @(negedge Clk_i) begin
    if (DataValid_o === 1'b1) begin
      vq.push_back(Data_o);
      vc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge Clk_i);
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) @(negedge Clk_i);
  endtask

  task automatic wr_coef(input logic [3:0] a, input logic [17:0] d);
    @(negedge Clk_i);
    CoeffAddr_i = a;
    CoeffData_i = d;
    CoeffWr_i   = 1'b1;
    @(negedge Clk_i);
    CoeffWr_i   = 1'b0;
  endtask

  task automatic send(input logic [17:0] x, output int t);
    @(negedge Clk_i);
    Data_i   = x;
    DataNd_i = 1'b1;
    t        = cyc + 1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    tick(GAP - 2);
  endtask

  task automatic send_n(input logic [17:0] x, input int n);
    int t;
    for (int i = 0; i < n; i++) send(x, t);
  endtask

  task automatic check_last(input string tag, input logic [17:0] exp);
    logic [17:0] v;
    tick(30);
    v = (vq.size() > 0) ? vq[vq.size()-1] : 18'bx;
    check(tag, {14'd0, v}, {14'd0, exp});
    vq.delete();
    vc.delete();
  endtask

  initial begin
    int t0;
    int t1;
    logic [17:0] v;
    int c;

    tick(3);
    check("rst_data",    {14'd0, Data_o}, 32'd0);
    check("rst_valid",   {31'd0, DataValid_o}, 32'd0);
    check("rst_busy",    {31'd0, Busy_o}, 32'd0);
    check("rst_overrun", {31'd0, Overrun_o}, 32'd0);
    @(negedge Clk_i);
    Rst_i = 1'b1;

    // Impulse response: h[k] = k*0x2000
    for (int k = 0; k < 16; k++) wr_coef(4'(k), 18'(k * 32'h2000));
    send_n(18'h0, 32);
    tick(30);
    vq.delete();
    vc.delete();
    send(18'h10000, t0);
    send(18'h0, t1);
    send_n(18'h0, 18);
    tick(30);
    check("imp_count", vq.size(), 32'd10);
    check("imp_latency", (vc.size() > 0) ? vc[0] : -1, t1 + 20);
    for (int i = 0; i < 10; i++) begin
      v = (vq.size() > 0) ? vq.pop_front() : 18'bx;
      check($sformatf("imp_out%0d", i), {14'd0, v}, (i < 8) ? (2 * i + 1) * 32'h1000 : 32'd0);
    end
    vc.delete();

    // DC gain of one
    for (int k = 0; k < 16; k++) wr_coef(4'(k), 18'h02000);
    send_n(18'h10000, 16);
    check_last("dc_full", 18'h10000);
    send_n(18'h10000, 4);
    tick(30);
    check("dc_count", vq.size(), 32'd2);
    for (int i = 0; i < 2; i++) begin
      v = (vq.size() > 0) ? vq.pop_front() : 18'bx;
      check($sformatf("dc_out%0d", i), {14'd0, v}, 32'h10000);
    end
    vc.delete();

    // Saturation both ways
    for (int k = 0; k < 16; k++) wr_coef(4'(k), 18'h1FFFF);
    send_n(18'h1FFFF, 16);
    check_last("sat_pos", 18'h1FFFF);
    send_n(18'h20000, 16);
    check_last("sat_neg", 18'h20000);

    // Rounding at exactly one half LSB
    wr_coef(4'd0, 18'h00001);
    for (int k = 1; k < 16; k++) wr_coef(4'(k), 18'h0);
    send(18'h30000, t0);
    send(18'h10000, t0);
    check_last("rnd_pos_half", 18'h00001);
    send(18'h10000, t0);
    send(18'h30000, t0);
    check_last("rnd_neg_half", 18'h3FFFF);

    // Overrun: second trigger 10 cycles after the first
    send(18'h10000, t1);
    @(negedge Clk_i);
    Data_i   = 18'h10000;
    DataNd_i = 1'b1;
    t0       = cyc + 1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    check("ovr_busy_trig_edge", {31'd0, Busy_o}, 32'd0);
    @(negedge Clk_i);
    check("ovr_busy_rise", {31'd0, Busy_o}, 32'd1);
    wait_to(t0 + 4);
    DataNd_i = 1'b1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    wait_to(t0 + 9);
    check("ovr_before", {31'd0, Overrun_o}, 32'd0);
    DataNd_i = 1'b1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    check("ovr_set", {31'd0, Overrun_o}, 32'd1);
    wait_to(t0 + 19);
    check("ovr_busy_19", {31'd0, Busy_o}, 32'd1);
    check("ovr_valid_19", {31'd0, DataValid_o}, 32'd0);
    @(negedge Clk_i);
    check("ovr_busy_20", {31'd0, Busy_o}, 32'd0);
    check("ovr_valid_20", {31'd0, DataValid_o}, 32'd1);
    tick(30);
    check("ovr_count", vq.size(), 32'd1);
    c = (vc.size() > 0) ? vc[0] : -1;
    check("ovr_latency", c, t0 + 20);
    v = (vq.size() > 0) ? vq[0] : 18'bx;
    check("ovr_data", {14'd0, v}, 32'd1);
    check("ovr_sticky", {31'd0, Overrun_o}, 32'd1);
    vq.delete();
    vc.delete();

    // Reset during the MAC pass, with phase left at 1
    send(18'h10000, t1);
    @(negedge Clk_i);
    Data_i   = 18'h10000;
    DataNd_i = 1'b1;
    t0       = cyc + 1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    wait_to(t0 + 3);
    DataNd_i = 1'b1;
    @(negedge Clk_i);
    DataNd_i = 1'b0;
    wait_to(t0 + 9);
    Rst_i = 1'b0;
    @(negedge Clk_i);
    check("mrst_data",    {14'd0, Data_o}, 32'd0);
    check("mrst_valid",   {31'd0, DataValid_o}, 32'd0);
    check("mrst_busy",    {31'd0, Busy_o}, 32'd0);
    check("mrst_overrun", {31'd0, Overrun_o}, 32'd0);
    @(negedge Clk_i);
    Rst_i = 1'b1;
    tick(30);
    check("mrst_no_valid", vq.size(), 32'd0);
    send(18'h10000, t0);
    send(18'h10000, t1);
    tick(30);
    check("mrst_count", vq.size(), 32'd1);
    c = (vc.size() > 0) ? vc[0] : -1;
    check("mrst_latency", c, t1 + 20);
    v = (vq.size() > 0) ? vq[0] : 18'bx;
    check("mrst_data_out", {14'd0, v}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/single_macc_decimator.md
# single_macc_decimator

Single-MAC polyphase-free FIR decimator: the receive-side counterpart of the team's single-MAC interpolator, sharing the same 16-tap, 18-bit Q1.17 coefficient format. It accepts one input sample per `DataNd_i` pulse and stores it in a circular data buffer. On every `DecimationK`-th accepted sample it runs one 16-cycle multiply-accumulate pass, then emits one rounded, saturated 18-bit output. It sits after the ADC/front-end, ahead of low-rate processing, in the `Clk_i` domain.

## Interface
- `DecimationK`, 2: output rate divisor; legal range 1..16.
- `FilterLength`, 16: number of taps, fixed at 16.
- `DataWidth`, 18: sample and coefficient width, Q1.17 signed.
- `Clk_i` in 1: single clock for all logic, including coefficient writes.
- `Rst_i` in 1: reset, asynchronous, active-low.
- `CoeffAddr_i` in 4: tap index for a coefficient write.
- `CoeffData_i` in 18: signed coefficient.
- `CoeffWr_i` in 1: writes `CoeffData_i` to `CoeffAddr_i` on the rising edge.
- `Data_i` in 18: signed input sample.
- `DataNd_i` in 1: one-cycle strobe, `Data_i` valid.
- `Data_o` out 18: signed decimated output; holds its value between strobes.
- `DataValid_o` out 1: one-cycle strobe, `Data_o` updated.
- `Busy_o` out 1: a MAC pass is in progress.
- `Overrun_o` out 1: sticky; a trigger arrived while busy.

## Operation
- Data buffer: 32 × 18 circular buffer (2 × `FilterLength`), 5-bit write pointer.
  - Every `DataNd_i` writes `Data_i` at the pointer, then increments the pointer, wrapping 31→0.
  - Writes continue during a pass and never corrupt the 16 samples being read.
- Phase counter: 0..`DecimationK`-1, incremented on every `DataNd_i`.
  - A trigger is a `DataNd_i` seen while phase = `DecimationK`-1; the counter then wraps to 0.
  - The first output therefore follows the `DecimationK`-th sample after reset.
- FSM states and transitions:
  - IDLE → MAC on an accepted trigger. The read base latches the address of the trigger sample (newest sample).
  - MAC: 16 cycles. Tap k reads coefficient k and data at base−k (mod 32). Coefficient 0 multiplies the newest sample.
  - MAC → DRAIN after tap 15.
  - DRAIN: 3 cycles (RAM read, product register, accumulate), then 1 round/saturate register cycle.
  - DRAIN → IDLE on the edge that asserts `DataValid_o`.
- Arithmetic:
  - 18×18 signed product (36 bits) feeds a 48-bit signed accumulator, cleared on tap 0.
  - Output = acc[34:17], rounded symmetric (half away from zero) using acc[16].
  - Saturate to 0x1FFFF / 0x20000 when acc[47:35] is not a sign extension of the rounded result.
- Overrun: a trigger outside IDLE sets `Overrun_o`, which stays set until reset. The trigger is dropped, the sample is still written, and the phase still advances.
- Coefficient writes while `Busy_o`=1 give an undefined output for that pass only.

## Timing
- Reset values: `Data_o`=0, `DataValid_o`=0, `Busy_o`=0, `Overrun_o`=0. Phase and pointer are 0 and the FSM is in IDLE. Buffer contents are not reset.
- `Busy_o` rises on the edge after the trigger edge and falls on the edge that asserts `DataValid_o`.
- Latency: `DataValid_o` is high for exactly one cycle, 20 edges after the edge that samples the triggering `DataNd_i`.
- Minimum trigger spacing is 20 cycles. A trigger coinciding with the `DataValid_o` cycle is accepted.
- `DecimationK`=1: every sample is a trigger; `DataNd_i` spacing must be ≥ 20.
- `Rst_i` low mid-pass aborts immediately: no `DataValid_o` is issued, and operation resumes from the reset state.

## Structure
- Package `single_macc_decimator_pkg`:
  - width constants (18, 36, 48);
  - `FilterLength`, buffer depth 32, address widths 4/5;
  - FSM state enum (IDLE, MAC, DRAIN);
  - rounding/saturation slice positions.
- Sub-module `decim_ctrl`: phase counter, write/read pointers, FSM, tap counter and overrun flag.
- The top level holds the coefficient RAM, data RAM, multiply-accumulate datapath and round/saturate stage.

## Test plan
- Impulse, `DecimationK`=2, h[k]=k·0x02000, input 0x10000 then zeros → `Data_o` sequence 0x01000, 0x03000, 0x05000 … 0x0F000, then 0.
- DC: all h=0x02000, constant input 0x10000 → after 16 inputs, every output is 0x10000.
- Saturation: all h=0x1FFFF. Input 0x1FFFF → 0x1FFFF. Input 0x20000 → sum −16 → 0x20000.
- Rounding: h0=0x00001, others 0. Input 0x10000 → 0x00001. Input 0x30000 → 0x3FFFF.
- Overrun: triggers 10 cycles apart → `Overrun_o`=1 from the second trigger, a single `DataValid_o`, and `Busy_o` timing unchanged.
- Reset mid-MAC (tap 8): all outputs read 0 while `Rst_i` is low. After release, the first `DataValid_o` follows `DecimationK` new samples plus 20 cycles.
